packet_unpadding: RTL

- Inverse of the SHA-1 input padding/alignment stage.
- Consumes padded 512-bit blocks (message || 0x80 || zeros || 64-bit big-endian bit length), strips the padding and emits the original message as an AXI-stream with per-byte tkeep.
- Used on the loopback/verification path and by any consumer that needs the raw message back from the block stream.
- Holds one block back, because the final message beat is only known once the length field in the last block arrives.

---
 rtl/packet_unpadding.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/packet_unpadding.sv
// packet_unpadding
//   Inverse of the SHA-1 padding/alignment stage. Consumes padded 512-bit
//   blocks (message || 0x80 || zeros || 64-bit big-endian bit length), strips
//   the padding and emits the original message as an AXI-stream with per-byte
//   keep. One block is held back because the final message beat is only known
//   once the length field in the last block arrives.
//
//   Parameters:
//     BLK_CNT_W     width of the per-packet block counter (saturates at all ones)
//
//   Ports:
//     clk, reset_n  clock, asynchronous active-low reset
//     o_tready_in   input ready (low during FLUSH_A / FLUSH_B)
//     i_tvalid_in   input block valid
//     i_tdata_in    padded block, byte 0 at [511:504]
//     i_tlast_in    final block of padded packet
//     i_tready_out  output ready
//     o_tvalid_out  output beat valid
//     o_tdata_out   message bytes, MSB-justified
//     o_tkeep_out   keep[i] qualifies data[8i+7:8i]; valid bytes are the top bits
//     o_tlast_out   final message beat
//     o_tuser_err   packet-format error, meaningful on the o_tlast_out beat only
//
//   Build option:
//     PAD_CHECK_EN  when defined, the 0x80 marker and zero fill are also
//                   verified on the final decode; errors otherwise come only
//                   from length alignment and block count.

module packet_unpadding #(
    parameter int unsigned BLK_CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    output logic         o_tready_in,
    input  logic         i_tvalid_in,
    input  logic [511:0] i_tdata_in,
    input  logic         i_tlast_in,
    input  logic         i_tready_out,
    output logic         o_tvalid_out,
    output logic [511:0] o_tdata_out,
    output logic [63:0]  o_tkeep_out,
    output logic         o_tlast_out,
    output logic         o_tuser_err
);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        STREAM  = 2'd1,
        FLUSH_A = 2'd2,
        FLUSH_B = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [511:0]           hold_q, hold_d;
    logic [511:0]           lastblk_q, lastblk_d;
    logic [BLK_CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]             r_q, r_d;
    logic                   err_q, err_d;

    logic                   tvalid_q, tvalid_d;
    logic [511:0]           tdata_q, tdata_d;
    logic [63:0]            tkeep_q, tkeep_d;
    logic                   tlast_q, tlast_d;
    logic                   tuser_err_q, tuser_err_d;

    logic                   slot_free;
    logic                   ready_in;
    logic                   accept;
    logic [BLK_CNT_W-1:0]   cnt_inc;
    logic [BLK_CNT_W-1:0]   dec_cnt;
    logic [63:0]            dec_bl;
    logic [5:0]             dec_r;
    logic [63:0]            dec_n;
    logic                   dec_err;
    logic                   pad_err;
    logic [63:0]            keep_topr;

`ifdef PAD_CHECK_EN
    // Marker lands in the held block when r >= 56 (length field needs its own
    // block), otherwise in the last block at offset r.
    function automatic logic pad_bad(input logic [511:0] hld,
                                     input logic [511:0] blk,
                                     input logic [5:0]   r);
        logic bad;
        logic [7:0] hb;
        logic [7:0] bb;
        bad = 1'b0;
        for (int unsigned i = 0; i < 64; i++) begin
            hb = hld[511 - 8*i -: 8];
            bb = blk[511 - 8*i -: 8];
            if (r >= 6'd56) begin
                if (i == 32'(r) && hb != 8'h80) bad = 1'b1;
                if (i > 32'(r) && hb != 8'h00)  bad = 1'b1;
                if (i < 56 && bb != 8'h00)      bad = 1'b1;
            end else begin
                if (i == 32'(r) && bb != 8'h80)          bad = 1'b1;
                if (i > 32'(r) && i < 56 && bb != 8'h00) bad = 1'b1;
            end
        end
        return bad;
    endfunction
`endif

    always_comb begin
        slot_free = !tvalid_q || i_tready_out;
        ready_in  = ((state_q == FILL) || (state_q == STREAM)) && slot_free;
        accept    = i_tvalid_in && ready_in;

        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + BLK_CNT_W'(1);
        dec_cnt   = (state_q == FILL) ? BLK_CNT_W'(1) : cnt_inc;
        dec_bl    = i_tdata_in[63:0];
        dec_r     = i_tdata_in[8:3];
        dec_n     = ({3'b000, dec_bl[63:3]} + 64'd72) >> 6;
`ifdef PAD_CHECK_EN
        pad_err   = pad_bad(hold_q, i_tdata_in, dec_r);
`else
        pad_err   = 1'b0;
`endif
        // A saturated counter can no longer represent the true block count.
        dec_err   = (|dec_bl[2:0]) || (&dec_cnt) ||
                    (64'(dec_cnt) != dec_n) || pad_err;

        keep_topr = ~(64'hFFFF_FFFF_FFFF_FFFF >> r_q);
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        lastblk_d   = lastblk_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        err_d       = err_q;

        tvalid_d    = tvalid_q && !i_tready_out;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        tuser_err_d = tuser_err_q;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    cnt_d = BLK_CNT_W'(1);
                    if (!i_tlast_in) begin
                        hold_d  = i_tdata_in;
                        state_d = STREAM;
                    end else begin
                        lastblk_d = i_tdata_in;
                        r_d       = dec_r;
                        err_d     = dec_err;
                        state_d   = FLUSH_B;
                    end
                end
            end

            STREAM: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (!i_tlast_in) begin
                        tvalid_d    = 1'b1;
                        tdata_d     = hold_q;
                        tkeep_d     = '1;
                        tlast_d     = 1'b0;
                        tuser_err_d = 1'b0;
                        hold_d      = i_tdata_in;
                    end else begin
                        lastblk_d = i_tdata_in;
                        r_d       = dec_r;
                        err_d     = dec_err;
                        state_d   = FLUSH_A;
                    end
                end
            end

            FLUSH_A: begin
                if (slot_free) begin
                    tvalid_d = 1'b1;
                    tdata_d  = hold_q;
                    if (r_q == 6'd0) begin
                        tkeep_d     = '1;
                        tlast_d     = 1'b1;
                        tuser_err_d = err_q;
                        state_d     = FILL;
                    end else if (r_q >= 6'd56) begin
                        // Last block carries only padding and is dropped.
                        tkeep_d     = keep_topr;
                        tlast_d     = 1'b1;
                        tuser_err_d = err_q;
                        state_d     = FILL;
                    end else begin
                        tkeep_d     = '1;
                        tlast_d     = 1'b0;
                        tuser_err_d = 1'b0;
                        state_d     = FLUSH_B;
                    end
                end
            end

            FLUSH_B: begin
                if (slot_free) begin
                    tvalid_d    = 1'b1;
                    tdata_d     = lastblk_q;
                    tkeep_d     = keep_topr;
                    tlast_d     = 1'b1;
                    tuser_err_d = err_q;
                    state_d     = FILL;
                end
            end

            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            hold_q      <= '0;
            lastblk_q   <= '0;
            cnt_q       <= '0;
            r_q         <= '0;
            err_q       <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tuser_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            lastblk_q   <= lastblk_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            err_q       <= err_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            tuser_err_q <= tuser_err_d;
        end
    end

    assign o_tready_in  = ready_in;
    assign o_tvalid_out = tvalid_q;
    assign o_tdata_out  = tdata_q;
    assign o_tkeep_out  = tkeep_q;
    assign o_tlast_out  = tlast_q;
    assign o_tuser_err  = tuser_err_q;

endmodule
